// File: rtl/alu_fmt_pkg.sv
// Shared constants, FSM state encoding and small helpers for the ALU result formatter.
package alu_fmt_pkg;

   localparam logic [3:0] DT_SIGNED   = 4'h1;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_X     = 8'h78;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ABS,
      ST_CONV,
      ST_SCAN,
      ST_SEND_SIGN,
      ST_SEND_DIG,
      ST_SEND_CR,
      ST_SEND_LF,
      ST_DONE
   } fmt_state_e;

   // Index of the most significant nonzero BCD digit; 0 when the value is zero.
   function automatic logic [3:0] msd_index(input logic [39:0] bcd);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 1; i < 10; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/alu_bin2bcd.sv
// Iterative double-dabble: 32-bit binary to 10 BCD digits, one bit per cycle.
module alu_bin2bcd (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start_i,
   input  logic [31:0] bin_i,
   output logic [39:0] bcd_o,
   output logic        done_o
);

   logic [31:0] bin_q;
   logic [39:0] bcd_q;
   logic [39:0] adj;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 10; i++) begin
         if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start_i) begin
         bin_q  <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         bin_q  <= {bin_q[30:0], 1'b0};
         bcd_q  <= {adj[38:0], bin_q[31]};
         cnt_q  <= cnt_q + 5'd1;
         busy_q <= (cnt_q != 5'd31);
         done_q <= (cnt_q == 5'd31);
      end else begin
         done_q <= 1'b0;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = done_q;

endmodule

// File: rtl/alu_res_fmt.sv
// Formats the ALU result as an ASCII decimal string over a valid/ready byte stream.
// Optional hex output ("0x" + 8 digits) is enabled with macro ALU_RES_FMT_HEX_EN.
module alu_res_fmt
   import alu_fmt_pkg::*;
#(
   parameter bit SEND_CR = 1'b1,
   parameter bit SEND_LF = 1'b1
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        alu_done,
   input  logic [3:0]  dtype,
   input  logic [31:0] calc_res,
`ifdef ALU_RES_FMT_HEX_EN
   input  logic        hex_mode,
`endif
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        fmt_busy,
   output logic        fmt_done
);

   fmt_state_e  state_q, state_d;
   logic        alu_done_q;
   logic [31:0] res_q, res_d;
   logic        neg_q, neg_d;
   logic        hex_q, hex_d;
   logic [3:0]  idx_q, idx_d;

   logic        start;
   logic        hex_in;
   logic        xfer;
   logic [31:0] mag;
   logic [39:0] bcd;
   logic        bcd_done;
   fmt_state_e  after_dig;

`ifdef ALU_RES_FMT_HEX_EN
   assign hex_in = hex_mode;
`else
   assign hex_in = 1'b0;
`endif

   assign start     = alu_done & ~alu_done_q;
   assign xfer      = tx_valid & tx_ready;
   assign mag       = neg_q ? (~res_q + 32'd1) : res_q;
   assign after_dig = SEND_CR ? ST_SEND_CR : (SEND_LF ? ST_SEND_LF : ST_DONE);

   alu_bin2bcd u_bin2bcd (
      .clk     (clk),
      .n_rst   (n_rst),
      .start_i (state_q == ST_ABS),
      .bin_i   (mag),
      .bcd_o   (bcd),
      .done_o  (bcd_done)
   );

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      neg_d   = neg_q;
      hex_d   = hex_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               res_d = calc_res;
               hex_d = hex_in;
               neg_d = ~hex_in & (dtype == DT_SIGNED) & calc_res[31];
               if (hex_in) begin
                  state_d = ST_SEND_SIGN;
                  idx_d   = 4'd1;
               end else begin
                  state_d = ST_ABS;
               end
            end
         end
         ST_ABS:  state_d = ST_CONV;
         ST_CONV: if (bcd_done) state_d = ST_SCAN;
         ST_SCAN: begin
            idx_d   = msd_index(bcd);
            state_d = neg_q ? ST_SEND_SIGN : ST_SEND_DIG;
         end
         ST_SEND_SIGN: begin
            // In hex mode this state carries the two-byte "0x" prefix, counted by idx.
            if (xfer) begin
               if (hex_q && idx_q[0]) begin
                  idx_d = 4'd0;
               end else begin
                  state_d = ST_SEND_DIG;
                  if (hex_q) idx_d = 4'd7;
               end
            end
         end
         ST_SEND_DIG: begin
            if (xfer) begin
               if (idx_q != 4'd0) idx_d = idx_q - 4'd1;
               else               state_d = after_dig;
            end
         end
         ST_SEND_CR: if (xfer) state_d = SEND_LF ? ST_SEND_LF : ST_DONE;
         ST_SEND_LF: if (xfer) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         alu_done_q <= 1'b0;
         res_q      <= '0;
         neg_q      <= 1'b0;
         hex_q      <= 1'b0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         alu_done_q <= alu_done;
         res_q      <= res_d;
         neg_q      <= neg_d;
         hex_q      <= hex_d;
         idx_q      <= idx_d;
      end
   end

   // Outputs decode registered state only, so they hold steady while tx_ready is low.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (state_q)
         ST_SEND_SIGN: begin
            tx_valid = 1'b1;
            tx_data  = hex_q ? (idx_q[0] ? ASCII_ZERO : ASCII_X) : ASCII_MINUS;
         end
         ST_SEND_DIG: begin
            tx_valid = 1'b1;
            tx_data  = hex_q ? hex_ascii(res_q[{idx_q[2:0], 2'b00} +: 4])
                             : (ASCII_ZERO + {4'h0, bcd[{idx_q, 2'b00} +: 4]});
         end
         ST_SEND_CR: begin
            tx_valid = 1'b1;
            tx_data  = ASCII_CR;
         end
         ST_SEND_LF: begin
            tx_valid = 1'b1;
            tx_data  = ASCII_LF;
         end
         default: ;
      endcase
   end

   assign fmt_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign fmt_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_res_fmt.sv
// Directed self-checking bench for alu_res_fmt (default SEND_CR=SEND_LF=1).
module tb_alu_res_fmt;

   logic        clk;
   logic        n_rst;
   logic        alu_done;
   logic [3:0]  dtype;
   logic [31:0] calc_res;
`ifdef ALU_RES_FMT_HEX_EN
   logic        hex_mode;
`endif
   logic        tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        fmt_busy;
   logic        fmt_done;

   int checks   = 0;
   int failures = 0;

   alu_res_fmt dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .alu_done (alu_done),
      .dtype    (dtype),
      .calc_res (calc_res),
`ifdef ALU_RES_FMT_HEX_EN
      .hex_mode (hex_mode),
`endif
      .tx_ready (tx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .fmt_busy (fmt_busy),
      .fmt_done (fmt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Triggers one result and checks the byte stream digits + CR + LF.
   // reedge_cyc > 0 raises a second alu_done edge (with other data) at that cycle.
   // hold keeps alu_done high for the whole string and beyond.
   task automatic run_case(input string name, input logic [3:0] dt, input logic [31:0] val,
                           input logic hx, input string digits, input bit bp,
                           input int reedge_cyc, input bit hold);
      byte         exp_q[$];
      int          nb, cyc, first_v;
      bit          fin, pstall, noisy;
      logic [7:0]  pdata;
      for (int i = 0; i < digits.len(); i++) exp_q.push_back(digits[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);

      @(negedge clk);
      dtype    = dt;
      calc_res = val;
`ifdef ALU_RES_FMT_HEX_EN
      hex_mode = hx;
`endif
      alu_done = 1'b1;
      tx_ready = bp ? 1'b0 : 1'b1;
      nb = 0; cyc = 0; first_v = -1; fin = 0; pstall = 0; pdata = 8'h00;

      while (!fin && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (!hold) alu_done = (cyc == reedge_cyc);
         if (reedge_cyc > 0 && cyc == reedge_cyc) calc_res = ~val;
         if (cyc == 1) begin
            checks++;
            if (fmt_busy !== 1'b1) begin
               failures++;
               $display("FAIL %s busy_after_capture: got %b expected 1", name, fmt_busy);
            end
         end
         if (tx_valid === 1'b1 && first_v < 0) first_v = cyc;
         if (pstall) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== pdata) begin
               failures++;
               $display("FAIL %s stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                        name, tx_valid, tx_data, pdata);
            end
         end
         if (fmt_done === 1'b1) begin
            fin = 1;
            checks++;
            if (nb != exp_q.size() || fmt_busy !== 1'b0) begin
               failures++;
               $display("FAIL %s done_state: got bytes=%0d busy=%b expected bytes=%0d busy=0",
                        name, nb, fmt_busy, exp_q.size());
            end
         end else begin
            if (bp) tx_ready = ($urandom_range(0, 1) == 1);
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
               checks++;
               if (nb >= exp_q.size()) begin
                  failures++;
                  $display("FAIL %s extra_byte: got %h expected no byte", name, tx_data);
               end else if (tx_data !== exp_q[nb]) begin
                  failures++;
                  $display("FAIL %s byte%0d: got %h expected %h", name, nb, tx_data, exp_q[nb]);
               end
               nb++;
            end
            pstall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            pdata  = tx_data;
         end
      end

      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: got no fmt_done in 400 cycles expected fmt_done", name);
      end
      checks++;
      if (first_v < 1 || first_v > 36) begin
         failures++;
         $display("FAIL %s first_valid_latency: got cycle %0d expected 1..36", name, first_v);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (fmt_done !== 1'b0 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s done_pulse_width: got done=%b valid=%b expected 0 0",
                  name, fmt_done, tx_valid);
      end
      if (hold || reedge_cyc > 0) begin
         noisy = 0;
         for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || fmt_busy !== 1'b0) noisy = 1;
         end
         checks++;
         if (noisy) begin
            failures++;
            $display("FAIL %s no_retrigger: got activity after completion expected idle", name);
         end
      end
      alu_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_rst    = 1'b0;
      alu_done = 1'b0;
      dtype    = 4'h0;
      calc_res = 32'h0;
`ifdef ALU_RES_FMT_HEX_EN
      hex_mode = 1'b0;
`endif
      tx_ready = 1'b1;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || fmt_busy !== 1'b0 || fmt_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b data=%h busy=%b done=%b expected 0 00 0 0",
                  tx_valid, tx_data, fmt_busy, fmt_done);
      end
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_decimal();
      run_case("unsigned_9",     4'h0, 32'd9,          1'b0, "9",           0, 0, 0);
      run_case("signed_m30",     4'h1, 32'hFFFFFFE2,   1'b0, "-30",         0, 0, 0);
      run_case("signed_m1",      4'h1, 32'hFFFFFFFF,   1'b0, "-1",          0, 0, 0);
      run_case("signed_max",     4'h1, 32'h7FFFFFFF,   1'b0, "2147483647",  0, 0, 0);
   endtask

   task automatic test_extremes();
      run_case("unsigned_max",   4'h0, 32'hFFFFFFFF,   1'b0, "4294967295",  0, 0, 0);
      run_case("signed_min",     4'h1, 32'h80000000,   1'b0, "-2147483648", 0, 0, 0);
      run_case("unsigned_zero",  4'h0, 32'h00000000,   1'b0, "0",           0, 0, 0);
      run_case("dtype2_as_uns",  4'h2, 32'hFFFFFFE2,   1'b0, "4294967266",  0, 0, 0);
   endtask

   task automatic test_backpressure();
      run_case("bp_9",           4'h0, 32'd9,          1'b0, "9",           1, 0, 0);
      run_case("bp_signed_min",  4'h1, 32'h80000000,   1'b0, "-2147483648", 1, 0, 0);
   endtask

   task automatic test_busy_ignore();
      run_case("edge_in_conv",   4'h0, 32'd12345,      1'b0, "12345",       0, 20, 0);
      run_case("edge_in_send",   4'h0, 32'd12345,      1'b0, "12345",       0, 38, 0);
      run_case("level_held",     4'h0, 32'd807,        1'b0, "807",         0, 0, 1);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      dtype    = 4'h1;
      calc_res = 32'h80000000;
      alu_done = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
      repeat (38) @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_inflight: got valid=%b expected 1", tx_valid);
      end
      n_rst = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || fmt_busy !== 1'b0 || fmt_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_outputs: got valid=%b data=%h busy=%b done=%b expected 0 00 0 0",
                  tx_valid, tx_data, fmt_busy, fmt_done);
      end
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      run_case("after_reset",    4'h0, 32'd1000000,    1'b0, "1000000",     0, 0, 0);
   endtask

`ifdef ALU_RES_FMT_HEX_EN
   task automatic test_hex();
      run_case("hex_beef",       4'h1, 32'h0000BEEF,   1'b1, "0x0000BEEF",  0, 0, 0);
      run_case("hex_neg",        4'h1, 32'hFA09C3D1,   1'b1, "0xFA09C3D1",  1, 0, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_decimal();
      test_extremes();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
`ifdef ALU_RES_FMT_HEX_EN
      test_hex();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
